// File: rtl/tt_sel_ctrl.sv
// rtl/tt_sel_ctrl.sv - spine select/enable controller driven by asynchronous ctrl pins
module tt_sel_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int MAX_ADDR    = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_sel_rst_n,
    input  logic       ctrl_sel_inc,
    input  logic       ctrl_ena,
    output logic [9:0] spine_sel,
    output logic       spine_ena,
    output logic [9:0] cur_addr,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_HOLD,
        ST_SETTLE,
        ST_ON
    } state_t;

    localparam logic [9:0] MAX_A  = 10'(MAX_ADDR);
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
    logic [SYNC_STAGES-1:0] ena_sync_q, ena_sync_d;
    logic                   inc_prev_q, inc_prev_d;
    state_t                 state_q, state_d;
    logic [9:0]             cnt_q, cnt_d;
    logic [3:0]             timer_q, timer_d;
    logic [9:0]             spine_sel_q, spine_sel_d;
    logic                   spine_ena_q, spine_ena_d;
    logic [9:0]             cur_addr_q, cur_addr_d;
    logic                   active_q, active_d;

    logic sel_rst_s, inc_s, ena_s, inc_evt;

    assign sel_rst_s = rst_sync_q[SYNC_STAGES-1];
    assign inc_s     = inc_sync_q[SYNC_STAGES-1];
    assign ena_s     = ena_sync_q[SYNC_STAGES-1];
    assign inc_evt   = inc_s & ~inc_prev_q;

    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], ctrl_sel_rst_n};
        inc_sync_d = {inc_sync_q[SYNC_STAGES-2:0], ctrl_sel_inc};
        ena_sync_d = {ena_sync_q[SYNC_STAGES-2:0], ctrl_ena};
        inc_prev_d = inc_s;
    end

    // Selection reset wins over everything; an inc event always detours through HOLD
    // so the enable drops a cycle before the address moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (!sel_rst_s) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            timer_d = '0;
        end else if (inc_evt && state_q != ST_HOLD) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (ena_s) begin
                        state_d = ST_SETTLE;
                        timer_d = RELOAD;
                    end
                end
                ST_HOLD: begin
                    cnt_d   = (cnt_q == MAX_A) ? 10'd0 : cnt_q + 10'd1;
                    state_d = ST_SETTLE;
                    timer_d = RELOAD;
                end
                ST_SETTLE: begin
                    if (!ena_s) begin
                        state_d = ST_OFF;
                    end else if (timer_q == 4'd0) begin
                        state_d = ST_ON;
                    end else begin
                        timer_d = timer_q - 4'd1;
                    end
                end
                ST_ON: begin
                    if (!ena_s) begin
                        state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // spine_sel is frozen while the spine is enabled, so a selection reset from ON
    // drops the enable first and moves the select one cycle later.
    always_comb begin
        spine_ena_d = (state_q == ST_ON);
        active_d    = (state_q == ST_ON);
        cur_addr_d  = cnt_q;
        spine_sel_d = spine_ena_q ? spine_sel_q
                                  : {cnt_q[9:6], cnt_q[0], cnt_q[5], cnt_q[4:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q  <= '1;
            inc_sync_q  <= '0;
            ena_sync_q  <= '0;
            inc_prev_q  <= 1'b0;
            state_q     <= ST_OFF;
            cnt_q       <= '0;
            timer_q     <= '0;
            spine_sel_q <= '0;
            spine_ena_q <= 1'b0;
            cur_addr_q  <= '0;
            active_q    <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            inc_sync_q  <= inc_sync_d;
            ena_sync_q  <= ena_sync_d;
            inc_prev_q  <= inc_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            spine_sel_q <= spine_sel_d;
            spine_ena_q <= spine_ena_d;
            cur_addr_q  <= cur_addr_d;
            active_q    <= active_d;
        end
    end

    assign spine_sel = spine_sel_q;
    assign spine_ena = spine_ena_q;
    assign cur_addr  = cur_addr_q;
    assign active    = active_q;

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// tb/tb_tt_sel_ctrl.sv - self-checking bench for tt_sel_ctrl
module tb_tt_sel_ctrl;
    localparam int S    = 2;
    localparam int T    = 4;
    localparam int MAXA = 1023;

    logic       clk = 1'b0;
    logic       rst_n, sel_rst_n, inc, ena;
    logic [9:0] spine_sel, cur_addr;
    logic       spine_ena, active;

    int total = 0, passed = 0, model_cnt = 0, viol = 0;

    always #5 clk = ~clk;

    tt_sel_ctrl #(.SYNC_STAGES(S), .SETTLE_CYC(T), .MAX_ADDR(MAXA)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_sel_rst_n(sel_rst_n), .ctrl_sel_inc(inc),
        .ctrl_ena(ena), .spine_sel(spine_sel), .spine_ena(spine_ena),
        .cur_addr(cur_addr), .active(active)
    );

    // Row/module view of the address: row = a/32, module = a%32.
    function automatic int exp_sel(int a);
        int row, m;
        row = (a / 32) % 32;
        m   = a % 32;
        return (row / 2) * 64 + (m % 2) * 32 + (row % 2) * 16 + m / 2;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fast_pulses(int n);
        for (int i = 0; i < n; i++) begin
            inc = 1'b1; tick(2);
            inc = 1'b0; tick(2);
        end
    endtask

    task automatic traced_pulse(output int fall, output int chg, output int rise);
        logic [9:0] sel0;
        sel0 = spine_sel;
        fall = -1; chg = -1; rise = -1;
        inc = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            #1;
            if (fall < 0 && !spine_ena) fall = e;
            if (chg < 0 && spine_sel != sel0) chg = e;
            if (fall >= 0 && rise < 0 && spine_ena) rise = e;
            if (e == 2) inc = 1'b0;
        end
    endtask

    logic       prev_valid = 1'b0;
    logic       prev_ena;
    logic [9:0] prev_sel;
    always @(posedge clk) begin
        #2;
        if (rst_n && prev_valid && spine_ena != prev_ena && spine_sel != prev_sel) begin
            viol++;
            $display("FAIL same_cycle: spine_ena and spine_sel both changed at %0t", $time);
        end
        prev_valid = rst_n;
        prev_ena   = spine_ena;
        prev_sel   = spine_sel;
    end

    typedef struct {
        int         n;
        bit         traced;
        int         addr;
        logic [9:0] sel;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int   e, fall, chg, rise, nact;

        vecs[0] = '{1,  1'b1, 1,  10'h020};
        vecs[1] = '{1,  1'b1, 2,  10'h001};
        vecs[2] = '{1,  1'b1, 3,  10'h021};
        vecs[3] = '{1,  1'b1, 4,  10'h002};
        vecs[4] = '{1,  1'b1, 5,  10'h022};
        vecs[5] = '{32, 1'b0, 37, 10'h032};
        vecs[6] = '{27, 1'b0, 64, 10'h040};
        vecs[7] = '{1,  1'b0, 65, 10'h060};
        vecs[8] = '{31, 1'b0, 96, 10'h050};

        rst_n = 1'b0; sel_rst_n = 1'b1; inc = 1'b0; ena = 1'b0;
        tick(3);
        check("rst_spine_sel", spine_sel, 0);
        check("rst_spine_ena", spine_ena, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_active", active, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_spine_ena", spine_ena, 0);

        ena = 1'b1;
        e = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            e++;
            #1;
            if (spine_ena) break;
        end
        check("ena_latency", e, S + 1 + T);
        check("ena_spine_sel", spine_sel, 0);
        check("ena_active", active, 1);

        foreach (vecs[i]) begin
            if (vecs[i].traced) begin
                traced_pulse(fall, chg, rise);
                check("pulse_ena_fall", fall, S + 1);
                check("pulse_sel_change", chg, S + 2);
                check("pulse_ena_rise", rise, S + T + 2);
            end else begin
                fast_pulses(vecs[i].n);
                tick(20);
            end
            model_cnt += vecs[i].n;
            check("vec_cur_addr", cur_addr, vecs[i].addr);
            check("vec_spine_sel", spine_sel, int'(vecs[i].sel));
            check("vec_spine_ena", spine_ena, 1);
        end

        fast_pulses(MAXA - model_cnt);
        model_cnt = MAXA;
        tick(20);
        check("max_cur_addr", cur_addr, MAXA);
        check("max_spine_sel", spine_sel, 10'h3FF);
        fast_pulses(1);
        model_cnt = 0;
        tick(20);
        check("wrap_cur_addr", cur_addr, 0);
        check("wrap_spine_sel", spine_sel, 0);
        check("wrap_no_x", int'($isunknown({spine_sel, spine_ena, cur_addr, active})), 0);
        check("wrap_spine_ena", spine_ena, 1);

        fast_pulses(3);
        model_cnt = 3;
        tick(20);
        ena = 1'b0;
        tick(10);
        check("ena_off_spine_ena", spine_ena, 0);
        check("ena_off_active", active, 0);
        check("ena_off_cur_addr", cur_addr, 3);
        ena = 1'b1;
        tick(20);
        check("ena_on_spine_ena", spine_ena, 1);
        check("ena_on_cur_addr", cur_addr, 3);

        sel_rst_n = 1'b0; inc = 1'b1;
        tick(6);
        check("selrst_cur_addr", cur_addr, 0);
        check("selrst_spine_ena", spine_ena, 0);
        check("selrst_active", active, 0);
        sel_rst_n = 1'b1;
        tick(4);
        inc = 1'b0;
        model_cnt = 0;
        tick(20);
        check("selrst_inc_lost", cur_addr, model_cnt);
        check("selrst_spine_sel", spine_sel, 0);
        check("selrst_reenable", spine_ena, 1);

        for (int it = 0; it < 30; it++) begin
            nact = int'($urandom_range(1, 4));
            for (int a = 0; a < nact; a++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ena = ~ena;
                    tick(int'($urandom_range(1, 4)));
                end else begin
                    inc = 1'b1; tick(int'($urandom_range(1, 4)));
                    inc = 1'b0; tick(int'($urandom_range(1, 4)));
                    model_cnt = (model_cnt + 1) % (MAXA + 1);
                end
            end
            tick(25);
            check("rand_cur_addr", cur_addr, model_cnt);
            check("rand_spine_sel", spine_sel, exp_sel(model_cnt));
            check("rand_spine_ena", spine_ena, int'(ena));
        end

        ena = 1'b1; sel_rst_n = 1'b0;
        tick(5);
        sel_rst_n = 1'b1;
        model_cnt = 0;
        fast_pulses(12);
        model_cnt = 12;
        tick(20);
        check("pre_cur_addr", cur_addr, 12);
        ena = 1'b0;
        tick(10);
        ena = 1'b1;
        tick(S + 2);
        check("settle_spine_ena", spine_ena, 0);
        check("settle_spine_sel", spine_sel, exp_sel(12));
        #2;
        inc = 1'b1; rst_n = 1'b0;
        #1;
        check("async_spine_sel", spine_sel, 0);
        check("async_spine_ena", spine_ena, 0);
        check("async_cur_addr", cur_addr, 0);
        check("async_active", active, 0);
        tick(3);
        rst_n = 1'b1;
        model_cnt = 1;
        tick(20);
        check("held_inc_one_event", cur_addr, model_cnt);
        check("post_rst_spine_ena", spine_ena, 1);
        inc = 1'b0;
        tick(10);
        check("held_inc_no_second", cur_addr, model_cnt);

        check("no_same_cycle_change", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
